// File: rtl/chacha_stream_xor_pkg.sv
// Shared ChaCha definitions: sigma constants, controller state encoding and
// helpers for building the block input state and selecting keystream words.
package chacha_stream_xor_pkg;

    localparam logic [31:0] CHACHA_C0 = 32'h6170_7865;
    localparam logic [31:0] CHACHA_C1 = 32'h3320_646e;
    localparam logic [31:0] CHACHA_C2 = 32'h7962_2d32;
    localparam logic [31:0] CHACHA_C3 = 32'h6b20_6574;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GEN    = 2'd1,
        ST_STREAM = 2'd2,
        ST_FLUSH  = 2'd3
    } chacha_state_e;

    function automatic logic [511:0] chacha_init_state(input logic [255:0] key,
                                                      input logic [31:0]  ctr,
                                                      input logic [95:0]  nonce);
        return {CHACHA_C0, CHACHA_C1, CHACHA_C2, CHACHA_C3, key, ctr, nonce};
    endfunction

    // Word 0 sits in the most significant 32 bits of the block.
    function automatic logic [31:0] chacha_ks_word(input logic [511:0] ks,
                                                   input logic [3:0]   idx);
        return ks[32 * (15 - int'(idx)) +: 32];
    endfunction

endpackage

// File: rtl/chacha_stream_xor.sv
// ChaCha stream controller: feeds the external block-function stage, captures
// each keystream block and XORs it word by word onto a handshaked data stream.
module chacha_stream_xor
    import chacha_stream_xor_pkg::*;
#(
    parameter int BLK_LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] key,
    input  logic [95:0]  nonce,
    input  logic [31:0]  ctr_init,
    output logic [511:0] state_out,
    input  logic [511:0] ks_in,
    input  logic [31:0]  in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [31:0]  out_data,
    output logic         out_valid,
    output logic         out_last,
    input  logic         out_ready,
    output logic         busy,
    output logic         done,
    output logic         ctr_wrap
);

    localparam int GW = (BLK_LATENCY < 1) ? 1 : $clog2(BLK_LATENCY + 1);
    localparam logic [GW-1:0] GEN_LOAD = GW'(BLK_LATENCY);

    chacha_state_e  state_q, state_d;
    logic [3:0]     idx_q, idx_d;
    logic [GW-1:0]  gen_cnt_q, gen_cnt_d;
    logic [31:0]    ctr_q, ctr_d;
    logic [255:0]   key_q, key_d;
    logic [95:0]    nonce_q, nonce_d;
    logic [511:0]   ks_q, ks_d;
    logic [511:0]   state_out_q, state_out_d;
    logic [31:0]    out_data_q, out_data_d;
    logic           out_valid_q, out_valid_d;
    logic           out_last_q, out_last_d;
    logic           ctr_wrap_q, ctr_wrap_d;
    logic           in_ready_c, xfer_c, done_c;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        gen_cnt_d   = gen_cnt_q;
        ctr_d       = ctr_q;
        key_d       = key_q;
        nonce_d     = nonce_q;
        ks_d        = ks_q;
        state_out_d = state_out_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        ctr_wrap_d  = 1'b0;
        done_c      = 1'b0;

        in_ready_c = (state_q == ST_STREAM) && (!out_valid_q || out_ready);
        xfer_c     = in_valid && in_ready_c;

        // Output register drains independently of the FSM, including during GEN.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (xfer_c) begin
            out_data_d  = in_data ^ chacha_ks_word(ks_q, idx_q);
            out_last_d  = in_last;
            out_valid_d = 1'b1;
            idx_d       = idx_q + 4'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    key_d       = key;
                    nonce_d     = nonce;
                    ctr_d       = ctr_init;
                    state_out_d = chacha_init_state(key, ctr_init, nonce);
                    gen_cnt_d   = GEN_LOAD;
                    idx_d       = 4'd0;
                    state_d     = ST_GEN;
                end
            end
            ST_GEN: begin
                if (gen_cnt_q == '0) begin
                    ks_d    = ks_in;
                    state_d = ST_STREAM;
                end else begin
                    gen_cnt_d = gen_cnt_q - GW'(1);
                end
            end
            ST_STREAM: begin
                if (xfer_c) begin
                    if (in_last) begin
                        state_d = ST_FLUSH;
                    end else if (idx_q == 4'd15) begin
                        ctr_d       = ctr_q + 32'd1;
                        ctr_wrap_d  = (ctr_q == 32'hFFFF_FFFF);
                        state_out_d = chacha_init_state(key_q, ctr_q + 32'd1, nonce_q);
                        gen_cnt_d   = GEN_LOAD;
                        state_d     = ST_GEN;
                    end
                end
            end
            ST_FLUSH: begin
                if (!out_valid_q || out_ready) begin
                    done_c  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            gen_cnt_q   <= '0;
            ctr_q       <= '0;
            key_q       <= '0;
            nonce_q     <= '0;
            ks_q        <= '0;
            state_out_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            ctr_wrap_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            gen_cnt_q   <= gen_cnt_d;
            ctr_q       <= ctr_d;
            key_q       <= key_d;
            nonce_q     <= nonce_d;
            ks_q        <= ks_d;
            state_out_q <= state_out_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            ctr_wrap_q  <= ctr_wrap_d;
        end
    end

    assign state_out = state_out_q;
    assign in_ready  = in_ready_c;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_c;
    assign ctr_wrap  = ctr_wrap_q;

endmodule

// File: tb/tb_chacha_stream_xor.sv
// Bench for chacha_stream_xor: a behavioural ChaCha20 block stage beside the DUT
// and a message-level reference model checked by a per-cycle output monitor.
module tb_chacha_stream_xor;

    localparam int LAT = 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [31:0]  ctr_init;
    logic [511:0] state_out;
    logic [511:0] ks_in;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_last;
    logic         out_ready;
    logic         busy;
    logic         done;
    logic         ctr_wrap;

    int checks = 0;
    int failures = 0;

    chacha_stream_xor #(.BLK_LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key(key), .nonce(nonce),
        .ctr_init(ctr_init), .state_out(state_out), .ks_in(ks_in),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .done(done), .ctr_wrap(ctr_wrap)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // Reference ChaCha20 block function (20 rounds, feed-forward add).
    function automatic logic [511:0] blk(input logic [511:0] s);
        logic [31:0] x [16];
        logic [31:0] w0 [16];
        logic [511:0] r;
        int a, b, c, d;
        for (int i = 0; i < 16; i++) begin
            x[i]  = s[511-32*i -: 32];
            w0[i] = x[i];
        end
        for (int rd = 0; rd < 10; rd++) begin
            for (int q = 0; q < 8; q++) begin
                a = q % 4;
                if (q < 4) begin
                    b = a + 4; c = a + 8; d = a + 12;
                end else begin
                    b = 4 + (a + 1) % 4; c = 8 + (a + 2) % 4; d = 12 + (a + 3) % 4;
                end
                x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 16);
                x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 12);
                x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 8);
                x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 7);
            end
        end
        for (int i = 0; i < 16; i++) r[511-32*i -: 32] = x[i] + w0[i];
        return r;
    endfunction

    function automatic logic [511:0] mk_state(input logic [255:0] k, input logic [31:0] c,
                                              input logic [95:0] n);
        return {32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574, k, c, n};
    endfunction

    // Keystream word for message word j: block (ctr + j/16), word j%16.
    function automatic logic [31:0] model_word(input logic [255:0] k, input logic [95:0] n,
                                               input logic [31:0] c, input int j);
        logic [511:0] b;
        b = blk(mk_state(k, c + 32'(j / 16), n));
        return b[511-32*(j%16) -: 32];
    endfunction

    // Block-function stage with LAT cycles of latency.
    logic [511:0] ks_pipe [LAT];
    always @(posedge clk) begin
        ks_pipe[0] <= blk(state_out);
        for (int i = 1; i < LAT; i++) ks_pipe[i] <= ks_pipe[i-1];
    end
    assign ks_in = ks_pipe[LAT-1];

    // out_ready driver: random or always-high, with forced low windows.
    int stall_req = 0;
    bit rand_ready = 1'b0;
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (stall_req > 0) begin
                out_ready = 1'b0;
                stall_req--;
            end else begin
                out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    logic [31:0]  exp_d [$];
    bit           exp_l [$];
    logic [31:0]  rx_q [$];
    logic [31:0]  ctr_log [$];
    int           wrap_cnt, done_cnt, hold_cnt;
    bit           mon_en = 1'b0;
    bit           prev_stall = 1'b0;
    logic [31:0]  prev_data;
    logic         prev_last;
    logic [511:0] prev_so = '0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid && out_ready) begin
                if (exp_d.size() == 0) begin
                    chk("unexpected_output", out_data, 32'h0);
                    chk("unexpected_output_valid", 1'b1, 1'b0);
                end else begin
                    chk("out_data", out_data, exp_d.pop_front());
                    chk("out_last", out_last, exp_l.pop_front());
                end
                chk("done_on_last", done, out_last);
                rx_q.push_back(out_data);
            end else if (done) begin
                chk("done_spurious", done, 1'b0);
            end
            if (done) done_cnt++;
            if (out_valid && !out_ready) begin
                hold_cnt++;
                chk("in_ready_in_stall", in_ready, 1'b0);
            end
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_data", out_data, prev_data);
                chk("hold_last", out_last, prev_last);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (ctr_wrap) wrap_cnt++;
            if (busy && state_out != prev_so) ctr_log.push_back(state_out[127:96]);
            prev_so = state_out;
        end
    end

    task automatic check_zero_outputs();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ctr_wrap", ctr_wrap, 1'b0);
        chk("rst_state_out", state_out, 512'h0);
    endtask

    task automatic do_start(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
        int cyc;
        @(posedge clk); #1;
        key = k; nonce = n; ctr_init = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("state_out_init", state_out, mk_state(k, c, n));
        chk("busy_after_start", busy, 1'b1);
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("first_in_ready_latency", cyc, LAT + 1);
    endtask

    task automatic run_msg(input logic [255:0] k, input logic [95:0] nn, input logic [31:0] c,
                           input int n, input bit zero, input int stall_at,
                           input int start_mid, input int abort_at);
        logic [31:0] d [$];
        logic [31:0] w;
        int kk;
        exp_d.delete(); exp_l.delete(); rx_q.delete(); ctr_log.delete();
        wrap_cnt = 0; done_cnt = 0; hold_cnt = 0; prev_so = '0;
        for (int j = 0; j < n; j++) begin
            w = zero ? 32'h0 : $urandom();
            d.push_back(w);
            exp_d.push_back(w ^ model_word(k, nn, c, j));
            exp_l.push_back(j == n - 1);
        end
        do_start(k, nn, c);
        for (int j = 0; j < n; j++) begin
            if (j == abort_at) begin
                mon_en = 1'b0;
                rst_n = 1'b0;
                exp_d.delete(); exp_l.delete();
                @(negedge clk);
                check_zero_outputs();
                @(posedge clk); #1;
                rst_n = 1'b1;
                done_cnt = 0; prev_stall = 1'b0; mon_en = 1'b1;
                repeat (4) begin @(posedge clk); #1; end
                chk("no_done_after_reset", done_cnt, 0);
                chk("idle_after_reset", busy, 1'b0);
                return;
            end
            if (j == start_mid) begin
                key = ~k; nonce = ~nn; ctr_init = ~c; start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                chk("busy_after_ignored_start", busy, 1'b1);
            end
            if (j == stall_at) stall_req = 5;
            in_valid = 1'b1; in_data = d[j]; in_last = (j == n - 1);
            kk = 0;
            do begin
                @(negedge clk);
                kk++;
            end while (!in_ready && kk < 200);
            if (!in_ready) begin
                chk("in_ready_timeout", in_ready, 1'b1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            in_valid = 1'b0; in_last = 1'b0;
            repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
        end
        kk = 0;
        while (done_cnt == 0 && kk < 300) begin
            @(posedge clk); #1;
            kk++;
        end
        chk("done_count", done_cnt, 1);
        chk("all_words_out", exp_d.size(), 0);
        chk("idle_after_done", busy, 1'b0);
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    initial begin
        logic [255:0] rfc_key;
        logic [95:0]  rfc_nonce;
        rst_n = 1'b0; start = 1'b0; key = '0; nonce = '0; ctr_init = '0;
        in_data = '0; in_valid = 1'b0; in_last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;

        // RFC 8439 block vector, zero plaintext so output equals keystream
        for (int i = 0; i < 8; i++)
            rfc_key[255-32*i -: 32] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
        rfc_nonce = {32'h09000000, 32'h4a000000, 32'h00000000};
        chk("model_rfc_w0", model_word(rfc_key, rfc_nonce, 32'd1, 0), 32'he4e7f110);
        chk("model_rfc_w15", model_word(rfc_key, rfc_nonce, 32'd1, 15), 32'h4e3c50a2);
        rand_ready = 1'b0;
        run_msg(rfc_key, rfc_nonce, 32'd1, 16, 1'b1, -1, -1, -1);
        chk("rfc_rx_count", rx_q.size(), 16);
        if (rx_q.size() == 16) begin
            chk("rfc_word0", rx_q[0], 32'he4e7f110);
            chk("rfc_word15", rx_q[15], 32'h4e3c50a2);
        end

        // Two-block message: counter field 1 then 2
        rand_ready = 1'b1;
        run_msg(rand256(), {$urandom(), $urandom(), $urandom()}, 32'd1, 20, 1'b0, -1, -1, -1);
        chk("ctr_log_size_20", ctr_log.size(), 2);
        if (ctr_log.size() == 2) begin
            chk("ctr_log0_20", ctr_log[0], 32'd1);
            chk("ctr_log1_20", ctr_log[1], 32'd2);
        end
        chk("no_wrap_20", wrap_cnt, 0);

        // Output back-pressure mid-block
        rand_ready = 1'b0;
        run_msg(rand256(), {$urandom(), $urandom(), $urandom()}, $urandom(), 10, 1'b0, 5, -1, -1);
        chk("stall_observed", hold_cnt >= 4, 1'b1);

        // Counter wrap
        rand_ready = 1'b1;
        run_msg(rand256(), {$urandom(), $urandom(), $urandom()}, 32'hFFFF_FFFF, 17, 1'b0, -1, -1, -1);
        chk("wrap_pulses", wrap_cnt, 1);
        chk("ctr_log_size_wrap", ctr_log.size(), 2);
        if (ctr_log.size() == 2) begin
            chk("ctr_log0_wrap", ctr_log[0], 32'hFFFF_FFFF);
            chk("ctr_log1_wrap", ctr_log[1], 32'h0);
        end

        // start during STREAM is ignored
        run_msg(rand256(), {$urandom(), $urandom(), $urandom()}, $urandom(), 12, 1'b0, -1, 4, -1);

        // Reset mid-message, then a normal message
        run_msg(rand256(), {$urandom(), $urandom(), $urandom()}, $urandom(), 16, 1'b0, -1, -1, 7);
        run_msg(rand256(), {$urandom(), $urandom(), $urandom()}, $urandom(), 9, 1'b0, -1, -1, -1);

        for (int t = 0; t < 4; t++)
            run_msg(rand256(), {$urandom(), $urandom(), $urandom()}, $urandom(),
                    $urandom_range(1, 40), 1'b0, -1, -1, -1);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
